// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests and grants.
// Ownership rotates on release, or when an owner overstays MAX_HOLD while another master waits.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic       bus_busy,
    output logic [1:0] owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // With preemption enabled the counter parks at MAX_HOLD, so the
    // equality test keeps firing until another master shows up.
    localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       grnt_q, grnt_d;

    logic [3:0] req;
    logic       other_found;
    logic [1:0] other_idx;
    logic       any_found;
    logic [1:0] any_idx;
    logic       own_req;
    logic       preempt;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    always_comb begin
        other_found = 1'b0;
        other_idx   = owner_q;
        for (int i = 3; i >= 1; i--) begin
            if (req[owner_q + 2'(i)]) begin
                other_found = 1'b1;
                other_idx   = owner_q + 2'(i);
            end
        end
        own_req   = req[owner_q];
        any_found = other_found | own_req;
        any_idx   = other_found ? other_idx : owner_q;
        preempt   = (MAX_HOLD != 0) && (hold_q == HOLD_SAT) && other_found;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        grnt_d  = grnt_q;
        case (state_q)
            IDLE: begin
                if (any_found) begin
                    state_d = GRANT;
                    owner_d = any_idx;
                    hold_d  = CNT_W'(1);
                    grnt_d  = ~(4'b0001 << any_idx);
                end
            end
            GRANT: begin
                if ((!own_req && other_found) || preempt) begin
                    owner_d = other_idx;
                    hold_d  = CNT_W'(1);
                    grnt_d  = ~(4'b0001 << other_idx);
                end else if (!own_req) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    grnt_d  = 4'hF;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grnt_d  = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            hold_q  <= '0;
            grnt_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= grnt_d;
        end
    end

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
    assign bus_busy = (state_q == GRANT);
    assign owner    = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter; two instances (MAX_HOLD=16 and 0)
// are compared every cycle against a queue-free arithmetic model of the arbitration rules.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset_;
   logic [3:0] reqN;
   wire  [3:0] grntA;
   wire  [3:0] grntB;
   wire        busyA, busyB;
   wire  [1:0] ownerA, ownerB;

   int checkCount = 0;
   int passCount  = 0;

   int mOwner[2];
   bit mBusy[2];
   int mHold[2];
   int maxHold[2] = '{16, 0};

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dutA (
      .clk(clk), .reset_(reset_),
      .m0_req_(reqN[0]), .m1_req_(reqN[1]), .m2_req_(reqN[2]), .m3_req_(reqN[3]),
      .m0_grnt_(grntA[0]), .m1_grnt_(grntA[1]), .m2_grnt_(grntA[2]), .m3_grnt_(grntA[3]),
      .bus_busy(busyA), .owner(ownerA)
   );

   bus_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dutB (
      .clk(clk), .reset_(reset_),
      .m0_req_(reqN[0]), .m1_req_(reqN[1]), .m2_req_(reqN[2]), .m3_req_(reqN[3]),
      .m0_grnt_(grntB[0]), .m1_grnt_(grntB[1]), .m2_grnt_(grntB[2]), .m3_grnt_(grntB[3]),
      .bus_busy(busyB), .owner(ownerB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      else
         passCount++;
   endtask

   // Reference model: owner/busy/hold-length bookkeeping straight from the arbitration rules.
   task automatic modelStep(input int k, input logic [3:0] req);
      int cand;
      cand = -1;
      if (!mBusy[k]) begin
         for (int i = 4; i >= 1; i--)
            if (req[(mOwner[k] + i) % 4]) cand = (mOwner[k] + i) % 4;
         if (cand >= 0) begin
            mBusy[k]  = 1'b1;
            mOwner[k] = cand;
            mHold[k]  = 1;
         end
      end else begin
         for (int i = 3; i >= 1; i--)
            if (req[(mOwner[k] + i) % 4]) cand = (mOwner[k] + i) % 4;
         if (!req[mOwner[k]] || (maxHold[k] != 0 && mHold[k] >= maxHold[k] && cand >= 0)) begin
            if (cand >= 0) begin
               mOwner[k] = cand;
               mHold[k]  = 1;
            end else begin
               mBusy[k] = 1'b0;
               mHold[k] = 0;
            end
         end else begin
            mHold[k]++;
         end
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mOwner[k] = 3;
         mBusy[k]  = 1'b0;
         mHold[k]  = 0;
      end
   endtask

   task automatic compareAll();
      logic [3:0] expGrnt;
      for (int k = 0; k < 2; k++) begin
         expGrnt = mBusy[k] ? ~(4'b0001 << mOwner[k]) : 4'hF;
         if (k == 0) begin
            checkOutput("grntA", 32'(grntA), 32'(expGrnt));
            checkOutput("busyA", 32'(busyA), 32'(mBusy[k]));
            checkOutput("ownerA", 32'(ownerA), 32'(mOwner[k]));
            checkOutput("oneGrantA", 32'($countones(~grntA) <= 1), 32'd1);
         end else begin
            checkOutput("grntB", 32'(grntB), 32'(expGrnt));
            checkOutput("busyB", 32'(busyB), 32'(mBusy[k]));
            checkOutput("ownerB", 32'(ownerB), 32'(mOwner[k]));
            checkOutput("oneGrantB", 32'($countones(~grntB) <= 1), 32'd1);
         end
      end
   endtask

   // Requests change on the falling edge; outputs are checked 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [3:0] reqActive);
      @(negedge clk);
      reqN = ~reqActive;
      @(posedge clk);
      modelStep(0, reqActive);
      modelStep(1, reqActive);
      #1;
      compareAll();
   endtask

   // Reset lands between edges so the grant removal must be asynchronous.
   task automatic pulseReset();
      @(posedge clk);
      #3;
      reset_ = 1'b0;
      #1;
      modelReset();
      checkOutput("rstGrntA", 32'(grntA), 32'hF);
      checkOutput("rstGrntB", 32'(grntB), 32'hF);
      checkOutput("rstBusyA", 32'(busyA), 32'd0);
      checkOutput("rstOwnerA", 32'(ownerA), 32'd3);
      @(negedge clk);
      reqN   = 4'hF;
      reset_ = 1'b1;
   endtask

   initial begin
      int heldCount;
      logic [3:0] rq;

      reset_ = 1'b0;
      reqN   = 4'hF;
      modelReset();
      #12;
      compareAll();
      @(negedge clk);
      reset_ = 1'b1;

      // All four request at once: master 0 wins first after reset.
      applyStimulus(4'b1111);
      checkOutput("allReqOwner", 32'(ownerA), 32'd0);

      // m0 holds with m2 waiting: A preempts after 16 cycles, B never does.
      pulseReset();
      heldCount = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(4'b0101);
         if (grntA[0] == 1'b0) heldCount++;
      end
      checkOutput("holdLenA", 32'(heldCount), 32'd16);
      checkOutput("preemptOwnerA", 32'(ownerA), 32'd2);

      pulseReset();
      heldCount = 0;
      for (int c = 0; c < 100; c++) begin
         applyStimulus(4'b0011);
         if (grntB[0] == 1'b0) heldCount++;
      end
      checkOutput("noPreemptB", 32'(heldCount), 32'd100);

      // Owner m1 releases while m0 and m3 wait: m3 next, then m0.
      pulseReset();
      applyStimulus(4'b0010);
      applyStimulus(4'b1011);
      applyStimulus(4'b1001);
      checkOutput("handoffM3", 32'(grntA), 32'b0111);
      applyStimulus(4'b0001);
      checkOutput("handoffM0", 32'(grntA), 32'b1110);

      // Sole owner m2 releases, then re-requests.
      applyStimulus(4'b0100);
      applyStimulus(4'b0000);
      checkOutput("idleOwner", 32'(ownerA), 32'd2);
      checkOutput("idleBusy", 32'(busyA), 32'd0);
      applyStimulus(4'b0100);
      checkOutput("regrantM2", 32'(grntA), 32'b1011);

      // Reset mid-grant, then m3 requests.
      pulseReset();
      applyStimulus(4'b1000);
      checkOutput("postRstOwner", 32'(ownerA), 32'd3);

      // Random sticky requests with occasional resets.
      rq = 4'b0000;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
         if ($urandom_range(0, 199) == 0) pulseReset();
         applyStimulus(rq);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
